hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage core (F/D/E/M/W). It owns every stall and flush strobe, sequences multi-cycle multiply/divide occupancy of the execute stage, and detects load-use hazards that forwarding cannot resolve. It also discards wrong-path fetches that were in flight when a redirect occurred. It sits beside the forwarding logic: forwarding covers ALU-to-ALU dependences, and this block covers everything that needs a bubble or a freeze.

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_ctrl_mdu_seq.sv | 79 +++++++
 rtl/hazard_ctrl.sv | 96 +++++++++
 tb/tb_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and default latencies for the hazard controller.
// MDU sequencer states and the counter width live here.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam int MUL_LAT_DEF = 3;
  localparam int DIV_LAT_DEF = 64;
  localparam int CNT_W       = 8;

endpackage

// File: rtl/hazard_ctrl_mdu_seq.sv
// Multiply/divide occupancy sequencer for the execute stage.
// Holds E for LAT cycles, then raises done for one cycle.
import hazard_ctrl_pkg::*;

module mdu_seq #(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic div,
  input  logic freeze,
  output logic stall,
  output logic busy,
  output logic done
);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lat_m1;

  assign lat_m1 = div ? CNT_W'(DIV_LAT - 1)
                      : CNT_W'(MUL_LAT - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A frozen pipeline holds both state and count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_d   = lat_m1;
            state_d = RUN;
          end
        end
        RUN: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      IDLE: stall = !freeze && start;
      RUN: begin
        stall = !freeze;
        busy  = 1'b1;
      end
      DONE: done = !freeze;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush strobes for F/D/E/M/W,
// MDU occupancy, load-use bubbles and wrong-path fetch discard.
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic       use1D,
  input  logic       use2D,
  input  logic [4:0] dstE,
  input  logic       memtoregE,
  input  logic       regwriteE,
  input  logic       redirectE,
  input  logic       mdu_startE,
  input  logic       mdu_divE,
  input  logic       i_busy,
  input  logic       d_busy,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       mdu_busy,
  output logic       mdu_done
);

  logic mdu_stall;
  logic lu_hit;
  logic lu_act;
  logic redir;
  logic pend_fl;
  logic pend_q, pend_d;

  mdu_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_mdu (
    .clk    (clk),
    .resetn (resetn),
    .start  (mdu_startE),
    .div    (mdu_divE),
    .freeze (d_busy),
    .stall  (mdu_stall),
    .busy   (mdu_busy),
    .done   (mdu_done)
  );

  assign lu_hit = memtoregE && regwriteE
               && (dstE != 5'd0)
               && ((use1D && (rs1D == dstE))
                || (use2D && (rs2D == dstE)));

  assign stallE = d_busy || mdu_stall;
  assign stallM = d_busy;
  assign flushW = d_busy;
  assign flushM = mdu_stall && !d_busy;

  assign redir  = redirectE && !stallE;
  // A redirect flushes the dependent op, so load-use yields to it.
  assign lu_act = lu_hit && !stallE && !redir;

  assign stallD = stallE || lu_act;
  assign stallF = stallD || i_busy;

  assign pend_fl = pend_q && !i_busy;

  assign flushD = !stallD && (redir || i_busy || pend_fl);
  assign flushE = redir || lu_act;

  // The pending discard is only consumed once D actually flushes.
  always_comb begin
    pend_d = pend_q;
    unique case (1'b1)
      redir && i_busy:    pend_d = 1'b1;
      pend_fl && !stallD: pend_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int MUL = 3;
  localparam int DIV = 64;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] rs1D, rs2D, dstE;
  logic       use1D, use2D;
  logic       memtoregE, regwriteE, redirectE;
  logic       mdu_startE, mdu_divE;
  logic       i_busy, d_busy;
  logic       stallF, stallD, stallE, stallM;
  logic       flushD, flushE, flushM, flushW;
  logic       mdu_busy, mdu_done;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: stall cycles left, done owed, pending discard
  int   m_left;
  bit   m_donep;
  bit   m_pend;
  logic [9:0] obs;

  hazard_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .use1D      (use1D),
    .use2D      (use2D),
    .dstE       (dstE),
    .memtoregE  (memtoregE),
    .regwriteE  (regwriteE),
    .redirectE  (redirectE),
    .mdu_startE (mdu_startE),
    .mdu_divE   (mdu_divE),
    .i_busy     (i_busy),
    .d_busy     (d_busy),
    .stallF     (stallF),
    .stallD     (stallD),
    .stallE     (stallE),
    .stallM     (stallM),
    .flushD     (flushD),
    .flushE     (flushE),
    .flushM     (flushM),
    .flushW     (flushW),
    .mdu_busy   (mdu_busy),
    .mdu_done   (mdu_done)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [9:0] got,
                       logic [9:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t got %b want %b",
               tag, $time, got, want);
    end
  endtask

  function automatic logic [9:0] outs();
    return {stallF, stallD, stallE, stallM,
            flushD, flushE, flushM, flushW,
            mdu_busy, mdu_done};
  endfunction

  task automatic clr_in();
    rs1D = '0; rs2D = '0; dstE = '0;
    use1D = 0; use2D = 0;
    memtoregE = 0; regwriteE = 0; redirectE = 0;
    mdu_startE = 0; mdu_divE = 0;
    i_busy = 0; d_busy = 0;
  endtask

  task automatic m_reset();
    m_left = 0;
    m_donep = 0;
    m_pend = 0;
  endtask

  task automatic do_reset_now();
    clr_in();
    resetn = 0;
    m_reset();
  endtask

  // One clock: model predicts, outputs compared at negedge.
  task automatic cycle();
    logic mst, ste, rd, lu, lue, std, stf;
    logic fd, fe, fm, fw, bz, dn;
    int nleft;
    bit ndone, npend;
    @(negedge clk);
    nleft = m_left;
    ndone = m_donep;
    npend = m_pend;
    mst = 0;
    dn = 0;
    bz = (m_left > 0);
    if (!d_busy) begin
      if (m_donep) begin
        dn = 1;
        ndone = 0;
      end else if (m_left > 0) begin
        mst = 1;
        nleft = m_left - 1;
        if (nleft == 0) ndone = 1;
      end else if (mdu_startE) begin
        mst = 1;
        nleft = (mdu_divE ? DIV : MUL) - 1;
      end
    end
    lu = memtoregE && regwriteE && dstE != 0 &&
         ((use1D && rs1D == dstE) ||
          (use2D && rs2D == dstE));
    ste = d_busy || mst;
    rd  = redirectE && !ste;
    lue = lu && !ste && !rd;
    std = ste || lue;
    stf = std || i_busy;
    fd  = !std && (rd || i_busy || (m_pend && !i_busy));
    fe  = rd || lue;
    fm  = mst && !d_busy;
    fw  = d_busy;
    if (rd && i_busy) npend = 1;
    else if (m_pend && !i_busy && !std) npend = 0;
    obs = outs();
    check("cyc", obs,
          {stf, std, ste, d_busy, fd, fe, fm, fw, bz, dn});
    @(posedge clk);
    if (resetn) begin
      m_left = nleft;
      m_donep = ndone;
      m_pend = npend;
    end else begin
      m_reset();
    end
    #1;
  endtask

  // Run an MDU op; returns cycles from start to done.
  task automatic mdu_run(bit dv, int bz0, int bzn,
                         output int lat);
    lat = -1;
    mdu_startE = 1;
    mdu_divE = dv;
    for (int k = 0; k < 200; k++) begin
      d_busy = (k >= bz0 && k < bz0 + bzn);
      cycle();
      if (d_busy) check("flushW", {9'b0, obs[2]}, 10'd1);
      if (obs[0]) begin
        lat = k;
        break;
      end
    end
    clr_in();
  endtask

  int lat;

  initial begin
    clr_in();
    m_reset();
    resetn = 0;
    #12;
    check("rst", outs(), 10'b0);
    @(posedge clk);
    #1;
    resetn = 1;
    cycle();
    check("idle", obs, 10'b0);

    // load x5 in E, add reads x5
    memtoregE = 1; regwriteE = 1; dstE = 5;
    rs1D = 5; use1D = 1;
    cycle();
    check("lu", obs, 10'b1100010000);
    clr_in();
    cycle();
    check("lu_after", obs, 10'b0);
    memtoregE = 1; regwriteE = 1; dstE = 0;
    rs1D = 0; use1D = 1;
    cycle();
    check("lu_x0", obs, 10'b0);
    clr_in();

    // multiply
    mdu_startE = 1;
    cycle();
    check("mul_t0", obs, 10'b1110001000);
    cycle();
    check("mul_t1", obs, 10'b1110001010);
    cycle();
    check("mul_t2", obs, 10'b1110001010);
    cycle();
    check("mul_done", obs, 10'b0000000001);
    clr_in();
    cycle();
    check("mul_idle", obs, 10'b0);

    mdu_run(1, 999, 0, lat);
    check("div_lat", 10'(lat), 10'(DIV));
    cycle();
    mdu_run(1, 20, 2, lat);
    check("div_dbusy", 10'(lat), 10'(DIV + 2));
    cycle();

    // redirect while fetch outstanding
    redirectE = 1; i_busy = 1;
    cycle();
    check("rd_t0", obs, 10'b1000110000);
    redirectE = 0;
    repeat (3) begin
      cycle();
      check("rd_ib", obs, 10'b1000100000);
    end
    i_busy = 0;
    cycle();
    check("rd_pend", obs, 10'b0000100000);
    cycle();
    check("rd_clr", obs, 10'b0);

    // load-use and redirect together
    memtoregE = 1; regwriteE = 1; dstE = 7;
    rs2D = 7; use2D = 1; redirectE = 1;
    cycle();
    check("lu_rd", obs, 10'b0000110000);
    clr_in();
    cycle();

    // reset in RUN with cnt = 10
    mdu_startE = 1;
    mdu_divE = 1;
    repeat (54) cycle();
    check("pre_rst", obs, 10'b1110001010);
    do_reset_now();
    #1;
    check("rst_run", outs(), 10'b0);
    cycle();
    resetn = 1;
    cycle();
    mdu_run(1, 999, 0, lat);
    check("div_rst", 10'(lat), 10'(DIV));
    cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset_now();
        cycle();
        resetn = 1;
        continue;
      end
      rs1D = 5'($urandom_range(0, 3));
      rs2D = 5'($urandom_range(0, 3));
      dstE = 5'($urandom_range(0, 3));
      use1D = 1'($urandom);
      use2D = 1'($urandom);
      memtoregE = ($urandom_range(0, 2) == 0);
      regwriteE = ($urandom_range(0, 3) != 0);
      redirectE = ($urandom_range(0, 7) == 0);
      mdu_startE = ($urandom_range(0, 9) == 0);
      mdu_divE = ($urandom_range(0, 4) == 0);
      i_busy = ($urandom_range(0, 3) == 0);
      d_busy = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
